// File: rtl/dac_frame_sequencer_pkg.sv
// Shared types, defaults and RAM address packing for the DAC frame sequencer.
// RAM addresses are {slot, bus}, so one slot's six codes sit in one 8-word block.
package dm_seq_pkg;

    localparam int DEF_NUM_BUSES = 6;
    localparam int DEF_NUM_CS    = 4;
    localparam int DEF_WORD_W    = 24;

    localparam int SLOT_W      = 2;
    localparam int BUS_W       = 3;
    localparam int RAM_ADDR_W  = SLOT_W + BUS_W;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_SETTLE,
        S_WAIT,
        S_LDAC,
        S_DONE
    } seq_state_e;

    function automatic logic [RAM_ADDR_W-1:0] make_ram_addr(
        input logic [SLOT_W-1:0] slot,
        input logic [BUS_W-1:0]  bus_idx
    );
        return {slot, bus_idx};
    endfunction

endpackage

// File: rtl/dac_frame_sequencer_if.sv
// Code-RAM read port and the shared launch/data/busy bundle of the six SPI masters.
// The sequencer drives through the master modport; the RAM and SPI side use slave.
interface dac_frame_sequencer_if #(
    parameter int NUM_BUSES = dm_seq_pkg::DEF_NUM_BUSES,
    parameter int WORD_W    = dm_seq_pkg::DEF_WORD_W
);

    logic [dm_seq_pkg::RAM_ADDR_W-1:0] RamAddr;
    logic [WORD_W-1:0]                 RamData;
    logic                              SpiStart;
    logic [dm_seq_pkg::SLOT_W-1:0]     SpiCsSel;
    logic [NUM_BUSES*WORD_W-1:0]       SpiData;
    logic [NUM_BUSES-1:0]              SpiBusy;

    modport master (
        output RamAddr,
        output SpiStart,
        output SpiCsSel,
        output SpiData,
        input  RamData,
        input  SpiBusy
    );

    modport slave (
        input  RamAddr,
        input  SpiStart,
        input  SpiCsSel,
        input  SpiData,
        output RamData,
        output SpiBusy
    );

endinterface

// File: rtl/dac_frame_sequencer_timer.sv
// Shared down-counter for the WAIT timeout and the LDAC pulse width.
// Reloaded on state entry; holds at zero so the owner can read zero as "expired".
module seq_cycle_timer #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/dac_frame_sequencer.sv
// Walks the four chip-select slots of one DAC frame across all six SPI buses,
// then pulses nLDacs so every DAC output updates together.
module dac_frame_sequencer
    import dm_seq_pkg::*;
#(
    parameter int NUM_BUSES      = DEF_NUM_BUSES,
    parameter int NUM_CS         = DEF_NUM_CS,
    parameter int WORD_W         = DEF_WORD_W,
    parameter int LDAC_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Enable,
    input  logic                   FrameStart,
    input  logic                   ClearStatus,
    dac_frame_sequencer_if.master  bus,
    output logic                   nLDacs,
    output logic                   Busy,
    output logic [FRAME_CNT_W-1:0] FrameCount,
    output logic                   Overrun,
    output logic                   TimeoutErr
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > LDAC_CYCLES) ? TIMEOUT_CYCLES : LDAC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FETCH_W = $clog2(NUM_BUSES + 1);

    seq_state_e                  state_q, state_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [FETCH_W-1:0]          fetch_cnt_q, fetch_cnt_d;
    logic [RAM_ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [NUM_BUSES*WORD_W-1:0] spi_data_q, spi_data_d;
    logic                        spi_start_q, spi_start_d;
    logic                        n_ldacs_q, n_ldacs_d;
    logic                        busy_q, busy_d;
    logic [FRAME_CNT_W-1:0]      frame_count_q, frame_count_d;
    logic                        overrun_q, overrun_d;
    logic                        timeout_err_q, timeout_err_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_zero;
    logic             timeout_set;

    seq_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_val),
        .enable     (tmr_en),
        .zero       (tmr_zero)
    );

    // RAM data lags its address by one clock, so lane b is captured on FETCH cycle b+1.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        fetch_cnt_d   = fetch_cnt_q;
        ram_addr_d    = ram_addr_q;
        spi_data_d    = spi_data_q;
        frame_count_d = frame_count_q;
        tmr_load      = 1'b0;
        tmr_load_val  = '0;
        tmr_en        = 1'b0;
        timeout_set   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (FrameStart && Enable) begin
                    state_d     = S_FETCH;
                    slot_d      = '0;
                    fetch_cnt_d = '0;
                    ram_addr_d  = make_ram_addr('0, '0);
                end
            end
            S_FETCH: begin
                for (int b = 0; b < NUM_BUSES; b++) begin
                    if (fetch_cnt_q == FETCH_W'(b + 1)) begin
                        spi_data_d[b*WORD_W +: WORD_W] = bus.RamData;
                    end
                end
                if (fetch_cnt_q < FETCH_W'(NUM_BUSES - 1)) begin
                    ram_addr_d = make_ram_addr(slot_q, BUS_W'(fetch_cnt_q + FETCH_W'(1)));
                end
                if (fetch_cnt_q == FETCH_W'(NUM_BUSES)) begin
                    state_d = S_START;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + FETCH_W'(1);
                end
            end
            S_START: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d      = S_WAIT;
                tmr_load     = 1'b1;
                tmr_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
            end
            S_WAIT: begin
                if (bus.SpiBusy == '0) begin
                    if (slot_q == SLOT_W'(NUM_CS - 1)) begin
                        state_d      = S_LDAC;
                        tmr_load     = 1'b1;
                        tmr_load_val = CNT_W'(LDAC_CYCLES - 1);
                    end else begin
                        state_d     = S_FETCH;
                        slot_d      = slot_q + SLOT_W'(1);
                        fetch_cnt_d = '0;
                        ram_addr_d  = make_ram_addr(slot_q + SLOT_W'(1), '0);
                    end
                end else if (tmr_zero) begin
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_LDAC: begin
                if (tmr_zero) begin
                    state_d = S_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                frame_count_d = frame_count_q + FRAME_CNT_W'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        spi_start_d = (state_d == S_START);
        n_ldacs_d   = (state_d != S_LDAC);
        busy_d      = (state_d != S_IDLE);

        // Sticky flags: a set event in the same cycle as ClearStatus wins.
        overrun_d = overrun_q;
        if (FrameStart && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (ClearStatus) begin
            overrun_d = 1'b0;
        end

        timeout_err_d = timeout_err_q;
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (ClearStatus) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            slot_q        <= '0;
            fetch_cnt_q   <= '0;
            ram_addr_q    <= '0;
            spi_data_q    <= '0;
            spi_start_q   <= 1'b0;
            n_ldacs_q     <= 1'b1;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            fetch_cnt_q   <= fetch_cnt_d;
            ram_addr_q    <= ram_addr_d;
            spi_data_q    <= spi_data_d;
            spi_start_q   <= spi_start_d;
            n_ldacs_q     <= n_ldacs_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.RamAddr  = ram_addr_q;
    assign bus.SpiStart = spi_start_q;
    assign bus.SpiCsSel = slot_q;
    assign bus.SpiData  = spi_data_q;
    assign nLDacs       = n_ldacs_q;
    assign Busy         = busy_q;
    assign FrameCount   = frame_count_q;
    assign Overrun      = overrun_q;
    assign TimeoutErr   = timeout_err_q;

endmodule
